// File: rtl/netdelay_sched.sv
// netdelay_sched: inverting net-delay scheduler with programmable rise/fall delays and inertial filtering.
// Rev 1.0
`default_nettype none

module netdelay_sched #(
  parameter int W        = 3,
  parameter int CNT_W    = 4,
  parameter int RISE_DEF = 2,
  parameter int FALL_DEF = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             x,
  input  logic             cfg_we,
  input  logic [CNT_W-1:0] cfg_rise,
  input  logic [CNT_W-1:0] cfg_fall,
  output logic [W-1:0]     y,
  output logic             busy,
  output logic             cancel_pulse,
  output logic [7:0]       glitch_cnt
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    WAIT_FALL = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] rise_q;
  logic [CNT_W-1:0] fall_q;
  logic             y_q;

  logic             tgt;
  logic [CNT_W-1:0] d_rise;
  logic [CNT_W-1:0] d_fall;

  assign tgt    = ~x;
  // A programmed delay of zero behaves as a single cycle.
  assign d_rise = (rise_q == '0) ? ONE : rise_q;
  assign d_fall = (fall_q == '0) ? ONE : fall_q;

  assign y    = {W{y_q}};
  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      y_q          <= 1'b0;
      cancel_pulse <= 1'b0;
      glitch_cnt   <= 8'd0;
      rise_q       <= CNT_W'(RISE_DEF);
      fall_q       <= CNT_W'(FALL_DEF);
    end else begin
      cancel_pulse <= 1'b0;

      if (cfg_we) begin
        rise_q <= cfg_rise;
        fall_q <= cfg_fall;
      end

      case (state)
        IDLE: begin
          if (tgt != y_q) begin
            if (tgt) begin
              if (d_rise == ONE) begin
                y_q <= 1'b1;
              end else begin
                cnt   <= d_rise - ONE;
                state <= WAIT_RISE;
              end
            end else begin
              if (d_fall == ONE) begin
                y_q <= 1'b0;
              end else begin
                cnt   <= d_fall - ONE;
                state <= WAIT_FALL;
              end
            end
          end
        end

        WAIT_RISE, WAIT_FALL: begin
          // Reversion wins over the commit, even on the final count.
          if (tgt == y_q) begin
            state        <= IDLE;
            cancel_pulse <= 1'b1;
            if (glitch_cnt != 8'hFF) begin
              glitch_cnt <= glitch_cnt + 8'd1;
            end
          end else if (cnt == ONE) begin
            y_q   <= (state == WAIT_RISE);
            state <= IDLE;
          end else begin
            cnt <= cnt - ONE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_netdelay_sched.sv
// tb_netdelay_sched: randomized and directed checks of netdelay_sched against an edge-indexed model.
// Rev 1.0
`default_nettype none

module tb_netdelay_sched;

  localparam int W     = 3;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             x;
  logic             cfg_we;
  logic [CNT_W-1:0] cfg_rise;
  logic [CNT_W-1:0] cfg_fall;
  logic [W-1:0]     y;
  logic             busy;
  logic             cancel_pulse;
  logic [7:0]       glitch_cnt;

  int total = 0;
  int bad   = 0;

  netdelay_sched #(.W(W), .CNT_W(CNT_W), .RISE_DEF(2), .FALL_DEF(1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .x            (x),
    .cfg_we       (cfg_we),
    .cfg_rise     (cfg_rise),
    .cfg_fall     (cfg_fall),
    .y            (y),
    .busy         (busy),
    .cancel_pulse (cancel_pulse),
    .glitch_cnt   (glitch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a pending transition is remembered by the absolute edge number on which it commits.
  int  m_edge;
  int  m_commit_edge;
  bit  m_pend;
  bit  m_y;
  bit  m_cancel;
  int  m_gc;
  int  m_rise;
  int  m_fall;

  function automatic int eff(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic model_reset();
    m_edge   = 0;
    m_pend   = 0;
    m_y      = 0;
    m_cancel = 0;
    m_gc     = 0;
    m_rise   = 2;
    m_fall   = 1;
  endtask

  task automatic model_edge();
    bit t;
    int d;
    t        = ~x;
    m_edge   = m_edge + 1;
    m_cancel = 0;
    if (m_pend) begin
      if (t == m_y) begin
        m_pend   = 0;
        m_cancel = 1;
        if (m_gc < 255) m_gc = m_gc + 1;
      end else if (m_edge == m_commit_edge) begin
        m_y    = t;
        m_pend = 0;
      end
    end else if (t != m_y) begin
      d = t ? eff(m_rise) : eff(m_fall);
      if (d == 1) begin
        m_y = t;
      end else begin
        m_pend        = 1;
        m_commit_edge = m_edge + d - 1;
      end
    end
    if (cfg_we) begin
      m_rise = int'(cfg_rise);
      m_fall = int'(cfg_fall);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    chk("y",            32'(y),            32'({W{m_y}}));
    chk("busy",         32'(busy),         32'(m_pend));
    chk("cancel_pulse", 32'(cancel_pulse), 32'(m_cancel));
    chk("glitch_cnt",   32'(glitch_cnt),   32'(m_gc));
  endtask

  // One clock: model advances with the DUT edge, outputs checked on the falling edge.
  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    else model_reset();
    @(negedge clk);
    compare_model();
  endtask

  task automatic cfg_write(input int r, input int f);
    cfg_we   = 1'b1;
    cfg_rise = CNT_W'(r);
    cfg_fall = CNT_W'(f);
    step();
    cfg_we   = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    x        = 1'b0;
    cfg_we   = 1'b0;
    cfg_rise = '0;
    cfg_fall = '0;
    model_reset();

    repeat (2) @(negedge clk);
    chk("reset_y",      32'(y),            32'h0);
    chk("reset_busy",   32'(busy),         32'h0);
    chk("reset_cancel", 32'(cancel_pulse), 32'h0);
    chk("reset_gc",     32'(glitch_cnt),   32'h0);

    // Release with x=0: default rise delay 2.
    rst_n = 1'b1;
    step();
    chk("rel_e1_busy", 32'(busy), 32'h1);
    chk("rel_e1_y",    32'(y),    32'h0);
    step();
    chk("rel_e2_y",    32'(y),    32'h7);
    chk("rel_e2_busy", 32'(busy), 32'h0);

    // Fall with default delay 1 lands on the first sampling edge.
    x = 1'b1;
    step();
    chk("fall1_y",    32'(y),    32'h0);
    chk("fall1_busy", 32'(busy), 32'h0);

    // Rise delay 4 with a 2-cycle low pulse is cancelled.
    cfg_write(4, 1);
    x = 1'b0;
    step();
    step();
    x = 1'b1;
    step();
    chk("glitch_cancel", 32'(cancel_pulse), 32'h1);
    chk("glitch_y",      32'(y),            32'h0);
    chk("glitch_gc",     32'(glitch_cnt),   32'h1);
    step();
    chk("glitch_cancel_drop", 32'(cancel_pulse), 32'h0);

    // Zero delays behave as single-cycle delays.
    cfg_write(0, 0);
    for (int i = 0; i < 6; i++) begin
      x = ~x;
      step();
      chk("zero_delay_y", 32'(y), 32'({W{~x}}));
    end

    // Config change during a countdown does not disturb it.
    x = 1'b1;
    cfg_write(5, 1);
    step();
    x = 1'b0;
    step();
    cfg_write(1, 1);
    step();
    step();
    chk("inflight_e4_y",    32'(y),    32'h0);
    chk("inflight_e4_busy", 32'(busy), 32'h1);
    step();
    chk("inflight_e5_y",    32'(y),    32'h7);
    x = 1'b1;
    step();
    chk("after_fall_y", 32'(y), 32'h0);
    x = 1'b0;
    step();
    chk("new_rise_d1_y", 32'(y), 32'h7);

    // Asynchronous reset mid-countdown.
    cfg_write(4, 1);
    x = 1'b1;
    step();
    x = 1'b0;
    step();
    step();
    chk("pre_reset_busy", 32'(busy), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst_y",    32'(y),    32'h0);
    chk("async_rst_busy", 32'(busy), 32'h0);
    step();
    @(negedge clk);
    rst_n = 1'b1;

    // 300 glitches saturate the counter (default rise delay 2).
    x = 1'b1;
    step();
    for (int i = 0; i < 300; i++) begin
      x = 1'b0;
      step();
      x = 1'b1;
      step();
    end
    chk("gc_saturated", 32'(glitch_cnt), 32'hFF);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) x = ~x;
      cfg_we   = ($urandom_range(0, 15) == 0);
      cfg_rise = CNT_W'($urandom_range(0, 6));
      cfg_fall = CNT_W'($urandom_range(0, 6));
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end else begin
        step();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/netdelay_sched.md
Name: netdelay_sched

Overview:
- Clocked controller that sequences the inverting net-delay path: drives a W-bit bus with the inverse of input `x`.
- Applies separately programmable rise and fall delays, counted in clock cycles.
- Inertial filtering: an input change that reverts before its delay expires is cancelled and never reaches the output. Cancellations are counted.
- Replaces the untimed `#(rise,fall)` wire-delay behaviour with a synthesizable, configurable scheduler feeding the W-bit output.

Parameters:
- W, 3, width of output bus `y`; all bits are always driven identical.
- CNT_W, 4, width of the delay registers and the countdown counter.
- RISE_DEF, 2, reset value of the rise delay register.
- FALL_DEF, 1, reset value of the fall delay register.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- x  input  1  data input; the target output level is t = ~x.
- cfg_we  input  1  write strobe for the delay registers.
- cfg_rise  input  CNT_W  new rise delay, captured when cfg_we=1.
- cfg_fall  input  CNT_W  new fall delay, captured when cfg_we=1.
- y  output  W  delayed inverse of x, replicated across all W bits.
- busy  output  1  high while a transition is pending (state != IDLE).
- cancel_pulse  output  1  one-cycle pulse when a pending transition is cancelled.
- glitch_cnt  output  8  saturating count of cancellations.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - y=0, state=IDLE, cnt=0, cancel_pulse=0, glitch_cnt=0.
  - rise_q=RISE_DEF, fall_q=FALL_DEF.
  - Any pending transition is dropped immediately.
- Effective delay: D = (reg==0) ? 1 : reg. D is latched into cnt when a transition starts. Later config writes do not affect an in-flight countdown.
- Config write: at any edge with cfg_we=1, rise_q<=cfg_rise and fall_q<=cfg_fall. Writes are allowed in any state. A transition detected on the same edge uses the old register values.
- States: IDLE, WAIT_RISE, WAIT_FALL.
- IDLE, each edge, compare t with y[0]:
  - Equal: stay in IDLE.
  - t=1, D=rise delay: if D==1, y<=all ones and stay in IDLE; otherwise cnt<=D-1 and go to WAIT_RISE.
  - t=0, D=fall delay: same as above, with y<=0 and WAIT_FALL.
- WAIT_RISE / WAIT_FALL, each edge, in priority order:
  - t==y[0] (input reverted): go to IDLE, y unchanged, cancel_pulse<=1, glitch_cnt<=glitch_cnt+1 (saturates at 255).
  - else if cnt==1: commit y (all ones for WAIT_RISE, 0 for WAIT_FALL) and go to IDLE.
  - else: cnt<=cnt-1.
- Latency: y changes on edge k+D-1, where k is the first edge that samples the new x. This equals D clock cycles after x is applied.
- Reversion on the exact commit edge resolves as a cancel.
- cancel_pulse is 0 on every edge without a cancel; it is never high for 2 consecutive cycles unless cancels occur on consecutive edges.
- busy is decoded from the state register (no combinational path from x). y[W-1:0] are always identical.
- A new transition can start on the edge immediately after a commit or cancel: IDLE evaluates on that edge.

Test Plan:
- Reset release with x=0, defaults: edge1 detect (busy=1), edge2 y=111, busy=0, cancel_pulse never asserted.
- y=111, x 0→1 held: first sampling edge gives y=000 (fall D=1); busy stays 0.
- cfg rise=4, y=000, x low for 2 cycles then high: cancel_pulse=1 for one cycle, y remains 000, glitch_cnt=1.
- cfg rise=0, fall=0: each x toggle held ≥1 cycle updates y on its first sampling edge (treated as D=1).
- cfg rise=5, x 1→0, cfg_we with rise=1 on the next edge: y still rises 5 cycles after x is applied; the next rise uses D=1.
- rst_n low during WAIT_RISE at cnt=2: y=000, busy=0 immediately; 300 glitches drive glitch_cnt to 255, where it holds.
